// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
// Ping-pong game engine. A single lit ball travels an 8-LED row; each
// player has to press their paddle button while the ball is on their end
// LED, at the latest in the same cycle as the next game-rate enable.
// The engine keeps both scores and stops once one of them reaches SCORE_MAX.
//
// Parameters:
//   SCORE_MAX  points needed to win (1..15)
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high game restart
//   ce         ball-step enable (one step per high cycle)
//   btn_l      left paddle button, active-high level
//   btn_r      right paddle button, active-high level
//   leds       LED row, bit 0 = left end, bit 7 = right end
//   score_l    left player score
//   score_r    right player score
//   game_over  high once either score reaches SCORE_MAX
//
// Optional build macro:
//   PONG_BTN_SYNC_EN  when defined, each button passes through a 2-flop
//                     synchronizer ahead of the edge detector.
module pong_ball_ctrl #(
  parameter int SCORE_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [7:0] leds,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_SERVE_L = 3'd0,
    S_SERVE_R = 3'd1,
    S_MOVE_R  = 3'd2,
    S_MOVE_L  = 3'd3,
    S_POINT   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [3:0] SCORE_MAX_C = 4'(SCORE_MAX);

  logic   btn_l_s, btn_r_s;
  logic   btn_l_q, btn_r_q;
  logic   press_l_s, press_r_s;

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       hit_q, hit_d;
  logic       server_r_q, server_r_d;  // 1: right player serves next
  logic [7:0] leds_q, leds_d;
  logic       game_over_q, game_over_d;

`ifdef PONG_BTN_SYNC_EN
  logic [1:0] sync_l_q, sync_r_q;

  // Two-stage synchronizers for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l_q <= 2'b00;
      sync_r_q <= 2'b00;
    end else begin
      sync_l_q <= {sync_l_q[0], btn_l};
      sync_r_q <= {sync_r_q[0], btn_r};
    end
  end

  assign btn_l_s = sync_l_q[1];
  assign btn_r_s = sync_r_q[1];
`else
  assign btn_l_s = btn_l;
  assign btn_r_s = btn_r;
`endif

  // Previous-sample registers for rising-edge press detection
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_l_q <= 1'b0;
      btn_r_q <= 1'b0;
    end else begin
      btn_l_q <= btn_l_s;
      btn_r_q <= btn_r_s;
    end
  end

  assign press_l_s = btn_l_s & ~btn_l_q;
  assign press_r_s = btn_r_s & ~btn_r_q;

  // Game state, ball position, scores and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SERVE_L;
      pos_q       <= 3'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      hit_q       <= 1'b0;
      server_r_q  <= 1'b0;
      leds_q      <= 8'h01;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hit_q       <= hit_d;
      server_r_q  <= server_r_d;
      leds_q      <= leds_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic: serving, ball travel, hit window and scoring
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hit_d      = hit_q;
    server_r_d = server_r_q;

    case (state_q)
      S_SERVE_L: begin
        pos_d = 3'd0;
        if (press_l_s) begin
          state_d = S_MOVE_R;
        end else begin
          state_d = S_SERVE_L;
        end
      end
      S_SERVE_R: begin
        pos_d = 3'd7;
        if (press_r_s) begin
          state_d = S_MOVE_L;
        end else begin
          state_d = S_SERVE_R;
        end
      end
      S_MOVE_R: begin
        if (pos_q != 3'd7) begin
          // Ball still travelling: early presses earn nothing.
          if (ce) begin
            pos_d = pos_q + 3'd1;
          end else begin
            pos_d = pos_q;
          end
        end else if (ce) begin
          // End of the receive window; a press in this very cycle still counts.
          hit_d = 1'b0;
          if (hit_q || press_r_s) begin
            state_d = S_MOVE_L;
            pos_d   = 3'd6;
          end else begin
            state_d    = S_POINT;
            score_l_d  = score_l_q + 4'd1;
            server_r_d = 1'b1;
          end
        end else if (press_r_s) begin
          hit_d = 1'b1;
        end else begin
          hit_d = hit_q;
        end
      end
      S_MOVE_L: begin
        if (pos_q != 3'd0) begin
          if (ce) begin
            pos_d = pos_q - 3'd1;
          end else begin
            pos_d = pos_q;
          end
        end else if (ce) begin
          hit_d = 1'b0;
          if (hit_q || press_l_s) begin
            state_d = S_MOVE_R;
            pos_d   = 3'd1;
          end else begin
            state_d    = S_POINT;
            score_r_d  = score_r_q + 4'd1;
            server_r_d = 1'b0;
          end
        end else if (press_l_s) begin
          hit_d = 1'b1;
        end else begin
          hit_d = hit_q;
        end
      end
      S_POINT: begin
        if (ce) begin
          if ((score_l_q == SCORE_MAX_C) || (score_r_q == SCORE_MAX_C)) begin
            state_d = S_OVER;
          end else if (server_r_q) begin
            state_d = S_SERVE_R;
            pos_d   = 3'd7;
          end else begin
            state_d = S_SERVE_L;
            pos_d   = 3'd0;
          end
        end else begin
          state_d = S_POINT;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_SERVE_L;
        pos_d   = 3'd0;
        hit_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so outputs are registered with it
  always_comb begin
    leds_d      = 8'h01;
    game_over_d = 1'b0;
    case (state_d)
      S_SERVE_L, S_SERVE_R, S_MOVE_R, S_MOVE_L: leds_d = 8'd1 << pos_d;
      S_POINT: leds_d = 8'hFF;
      S_OVER: begin
        game_over_d = 1'b1;
        if (score_l_d == SCORE_MAX_C) begin
          leds_d = 8'h0F;
        end else begin
          leds_d = 8'hF0;
        end
      end
      default: leds_d = 8'h01;
    endcase
  end

  assign leds      = leds_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
module tb_pong_ball_ctrl;

`ifdef PONG_BTN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic [7:0] leds;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  // {leds, score_l, score_r, game_over}
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [16:0] got;
  int tests_run = 0;
  int tests_failed = 0;

  pong_ball_ctrl #(.SCORE_MAX(2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .btn_l(btn_l), .btn_r(btn_r),
    .leds(leds), .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // One clock with the given ce; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  // Raise a button so its press reaches the FSM in the last of LAT cycles,
  // with ce applied only in that cycle if requested; then release it.
  task automatic do_press(input logic right, input logic ce_last);
    if (right) btn_r = 1'b1; else btn_l = 1'b1;
    for (int i = 0; i < LAT - 1; i++) cyc(1'b0);
    cyc(ce_last);
    btn_r = 1'b0;
    btn_l = 1'b0;
    for (int i = 0; i < LAT; i++) cyc(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    exp_q.push_back({8'h01, 4'd0, 4'd0, 1'b0});
    cyc(1'b1);
    reset = 1'b0;
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL reset got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'h01, 4'd0, 4'd0, 1'b0});
      cyc(1'b1);
      got = {leds, score_l, score_r, game_over};
      e = exp_q.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL serve_ignores_ce%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_rally;
    logic [7:0] l;
    do_press(1'b0, 1'b0);
    // Right-going crossing, then right returns, left returns same-cycle.
    for (int i = 1; i <= 7; i++) begin
      l = 8'h01 << i;
      exp_q.push_back({l, 4'd0, 4'd0, 1'b0});
      cyc(1'b1);
      got = {leds, score_l, score_r, game_over};
      e = exp_q.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL rally_right%0d got=%h exp=%h", i, got, e);
      end
    end
    do_press(1'b1, 1'b0);
    exp_q.push_back({8'h40, 4'd0, 4'd0, 1'b0});
    cyc(1'b1);
    for (int i = 5; i >= 0; i--) begin
      l = 8'h01 << i;
      exp_q.push_back({l, 4'd0, 4'd0, 1'b0});
      cyc(1'b1);
    end
    do_press(1'b0, 1'b1);
    exp_q.push_back({8'h02, 4'd0, 4'd0, 1'b0});
    // Only the final states are compared here; drain the queue in order.
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL rally_left_return got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_same_cycle_hit;
    for (int i = 0; i < 6; i++) cyc(1'b1);
    exp_q.push_back({8'h80, 4'd0, 4'd0, 1'b0});
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL at_right_end got=%h exp=%h", got, e);
    end
    do_press(1'b1, 1'b1);
    exp_q.push_back({8'h40, 4'd0, 4'd0, 1'b0});
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL same_cycle_hit got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_early_press_miss;
    for (int i = 0; i < 6; i++) cyc(1'b1);      // pos 0
    do_press(1'b0, 1'b0);                       // hit flag at left end
    cyc(1'b1);                                  // pos 1
    for (int i = 0; i < 4; i++) cyc(1'b1);      // pos 5
    exp_q.push_back({8'h20, 4'd0, 4'd0, 1'b0});
    do_press(1'b1, 1'b0);                       // early, must be ignored
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL early_press_pos got=%h exp=%h", got, e);
    end
    cyc(1'b1);
    cyc(1'b1);                                  // pos 7
    exp_q.push_back({8'hFF, 4'd1, 4'd0, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL right_miss got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_handoff;
    exp_q.push_back({8'h80, 4'd1, 4'd0, 1'b0});
    cyc(1'b1);
    do_press(1'b0, 1'b0);                       // wrong server
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL serve_r_hold got=%h exp=%h", got, e);
    end
    do_press(1'b1, 1'b0);
    exp_q.push_back({8'h40, 4'd1, 4'd0, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL serve_r_start got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 6; i++) cyc(1'b1);      // pos 0, left misses
    exp_q.push_back({8'hFF, 4'd1, 4'd1, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL left_miss got=%h exp=%h", got, e);
    end
    exp_q.push_back({8'h01, 4'd1, 4'd1, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL serve_l_back got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_win;
    do_press(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1);
    exp_q.push_back({8'hFF, 4'd2, 4'd1, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL final_point got=%h exp=%h", got, e);
    end
    exp_q.push_back({8'h0F, 4'd2, 4'd1, 1'b1});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL game_over got=%h exp=%h", got, e);
    end
    do_press(1'b0, 1'b1);
    do_press(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    exp_q.push_back({8'h0F, 4'd2, 4'd1, 1'b1});
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL over_frozen got=%h exp=%h", got, e);
    end
    reset = 1'b1;
    btn_l = 1'b1;                               // reset wins over press and ce
    exp_q.push_back({8'h01, 4'd0, 4'd0, 1'b0});
    cyc(1'b1);
    reset = 1'b0;
    btn_l = 1'b0;
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL over_reset got=%h exp=%h", got, e);
    end
    for (int i = 0; i < LAT + 1; i++) cyc(1'b0);
  endtask

  task automatic test_latency;
    logic [7:0] l;
    btn_l = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      l = (i == LAT + 1) ? 8'h02 : 8'h01;
      exp_q.push_back({l, 4'd0, 4'd0, 1'b0});
      cyc(1'b1);
      got = {leds, score_l, score_r, game_over};
      e = exp_q.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL latency_cyc%0d got=%h exp=%h", i, got, e);
      end
    end
    btn_l = 1'b0;
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_held_button;
    btn_l = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b0);
    exp_q.push_back({8'h01, 4'd0, 4'd0, 1'b0});
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL held_serve got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 7; i++) cyc(1'b1);
    btn_r = 1'b1;
    for (int i = 0; i < LAT - 1; i++) cyc(1'b0);
    cyc(1'b1);
    btn_r = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1);      // back at pos 0, btn_l still held
    exp_q.push_back({8'hFF, 4'd0, 4'd1, 1'b0});
    cyc(1'b1);
    got = {leds, score_l, score_r, game_over};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL held_single_press got=%h exp=%h", got, e);
    end
    btn_l = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_rally();
    test_same_cycle_hit();
    test_early_press_miss();
    test_handoff();
    test_win();
    test_latency();
    test_held_button();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
